// File: rtl/rgmii_frame_tx.sv
// rgmii_frame_tx
//   Builds and transmits one Ethernet II frame per request over an RGMII
//   transmit interface:
//   preamble, SFD, header, payload, optional zero padding, FCS, then an
//   inter-frame gap.
//
//   Configuration macro: RGMII_FRAME_TX_PAD_EN
//     Defined   - short payloads are zero-padded up to MIN_PAYLOAD bytes.
//     Undefined - no PAD state; short payloads go out unpadded.
//
//   Ports
//     clk125     in   125 MHz byte clock, all state on the rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   frame request, only looked at while idle
//     dst_mac    in   destination MAC, bits [7:0] sent first
//     src_mac    in   source MAC, bits [7:0] sent first
//     ethertype  in   sent [15:8] first
//     len        in   payload byte count (clamped to MAX_PAYLOAD)
//     s_data     in   payload byte
//     s_valid    in   payload byte valid
//     s_ready    out  payload byte accepted this cycle (payload phase only)
//     busy       out  frame in progress (cycle after accept through done)
//     done       out  one-cycle pulse at the end of the inter-frame gap
//     underrun   out  sticky: payload starved during the current/last frame
//     txctl      out  RGMII TX_CTL (frame byte valid)
//     txd        out  RGMII TXD, DDR: low nibble while clk125=1, high nibble while clk125=0
module rgmii_frame_tx #(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic        clk125,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [10:0] len,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        txctl,
  output logic [3:0]  txd
);

  // Counters are 11 bits wide, so the limits must fit; the inter-frame gap needs at least one cycle.
  if (MAX_PAYLOAD > 2047 || MIN_PAYLOAD > 2047 || IFG_BYTES < 1) begin : g_param_check
    $error("rgmii_frame_tx: parameter out of range");
  end

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StHdr,
    StPay,
`ifdef RGMII_FRAME_TX_PAD_EN
    StPad,
`endif
    StFcs,
    StIfg
  } state_t;

  localparam logic [10:0] MaxLen = 11'(MAX_PAYLOAD);
`ifdef RGMII_FRAME_TX_PAD_EN
  localparam logic [10:0] MinLen = 11'(MIN_PAYLOAD);
`endif

  state_t         state_q;
  logic [10:0]    cnt_q;      // byte index within PRE/HDR/FCS/IFG
  logic [10:0]    dcnt_q;     // payload + pad bytes emitted so far
  logic [10:0]    len_q;
  logic [111:0]   hdr_q;      // header shifted out LSB first
  logic [31:0]    crc_q;
  logic [7:0]     sel_byte_q; // stage 1: selected byte
  logic           sel_vld_q;
  logic [7:0]     out_byte_q; // stage 2: byte on the wire

  logic [10:0]    len_clamped;
  logic [7:0]     cur_byte;
  logic           cur_vld;
  logic [31:0]    crc_next;
  logic [31:0]    fcs_word;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Where to go once n payload/pad bytes have been emitted.
  function automatic state_t data_next(input logic [10:0] n);
    if (n < len_q) return StPay;
`ifdef RGMII_FRAME_TX_PAD_EN
    if (n < MinLen) return StPad;
`endif
    return StFcs;
  endfunction

  assign len_clamped = (len > MaxLen) ? MaxLen : len;

  // An underrun frame carries the correct CRC un-complemented, i.e. the inverse of a valid FCS.
  assign fcs_word = underrun ? crc_q : ~crc_q;

  assign s_ready = (state_q == StPay);

  always_comb begin
    cur_byte = 8'h00;
    cur_vld  = 1'b0;
    case (state_q)
      StPre: begin
        cur_byte = 8'h55;
        cur_vld  = 1'b1;
      end
      StSfd: begin
        cur_byte = 8'hD5;
        cur_vld  = 1'b1;
      end
      StHdr: begin
        cur_byte = hdr_q[7:0];
        cur_vld  = 1'b1;
      end
      StPay: begin
        cur_byte = s_valid ? s_data : 8'h00;
        cur_vld  = 1'b1;
      end
`ifdef RGMII_FRAME_TX_PAD_EN
      StPad: begin
        cur_byte = 8'h00;
        cur_vld  = 1'b1;
      end
`endif
      StFcs: begin
        cur_byte = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        cur_vld  = 1'b1;
      end
      default: begin
        cur_byte = 8'h00;
        cur_vld  = 1'b0;
      end
    endcase
  end

  assign crc_next = crc32_byte(crc_q, cur_byte);

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 11'd0;
      dcnt_q     <= 11'd0;
      len_q      <= 11'd0;
      hdr_q      <= '0;
      crc_q      <= 32'h0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sel_byte_q <= 8'h00;
      sel_vld_q  <= 1'b0;
      out_byte_q <= 8'h00;
      txctl      <= 1'b0;
    end else begin
      sel_byte_q <= cur_byte;
      sel_vld_q  <= cur_vld;
      out_byte_q <= sel_byte_q;
      txctl      <= sel_vld_q;
      done       <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start) begin
            hdr_q    <= {ethertype[7:0], ethertype[15:8], src_mac, dst_mac};
            len_q    <= len_clamped;
            underrun <= 1'b0;
            busy     <= 1'b1;
            cnt_q    <= 11'd0;
            dcnt_q   <= 11'd0;
            state_q  <= StPre;
          end
        end
        StPre: begin
          crc_q <= 32'hFFFFFFFF;
          if (cnt_q == 11'd6) begin
            cnt_q   <= 11'd0;
            state_q <= StSfd;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        StSfd: begin
          crc_q   <= 32'hFFFFFFFF;
          cnt_q   <= 11'd0;
          state_q <= StHdr;
        end
        StHdr: begin
          crc_q <= crc_next;
          hdr_q <= {8'h00, hdr_q[111:8]};
          if (cnt_q == 11'd13) begin
            cnt_q   <= 11'd0;
            dcnt_q  <= 11'd0;
            state_q <= data_next(11'd0);
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        StPay: begin
          crc_q  <= crc_next;
          dcnt_q <= dcnt_q + 11'd1;
          if (!s_valid) underrun <= 1'b1;
          state_q <= data_next(dcnt_q + 11'd1);
        end
`ifdef RGMII_FRAME_TX_PAD_EN
        StPad: begin
          crc_q   <= crc_next;
          dcnt_q  <= dcnt_q + 11'd1;
          state_q <= data_next(dcnt_q + 11'd1);
        end
`endif
        StFcs: begin
          if (cnt_q == 11'd3) begin
            cnt_q   <= 11'd0;
            state_q <= StIfg;
            // With a one-cycle gap the done pulse lands in that single IFG cycle.
            done    <= (IFG_BYTES == 1);
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        StIfg: begin
          // done is high during the last gap cycle so the following cycle is a plain IDLE
          // in which a held start is accepted.
          done <= ({21'd0, cnt_q} + 32'd2 == IFG_BYTES);
          if ({21'd0, cnt_q} + 32'd1 == IFG_BYTES) begin
            cnt_q   <= 11'd0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // DDR output: low nibble on the high clock phase, high nibble on the low phase.
  assign txd = clk125 ? out_byte_q[3:0] : out_byte_q[7:4];

endmodule

// File: tb/tb_rgmii_frame_tx.sv
`timescale 1ns/1ps
module tb_rgmii_frame_tx;

  logic        clk125 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [10:0] len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        txctl;
  logic [3:0]  txd;

  rgmii_frame_tx dut (
    .clk125    (clk125),
    .rst_n     (rst_n),
    .start     (start),
    .dst_mac   (dst_mac),
    .src_mac   (src_mac),
    .ethertype (ethertype),
    .len       (len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .txctl     (txctl),
    .txd       (txd)
  );

  always #4 clk125 = ~clk125;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wire capture: reassemble each DDR byte while txctl is high.
  logic [7:0] cap_q[$];
  logic [3:0] lo_nib;
  always begin
    @(posedge clk125);
    #1 lo_nib = txd;
    @(negedge clk125);
    #1;
    if (txctl) cap_q.push_back({txd, lo_nib});
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [7:0] exp_q[$];

  // Expected wire bytes for one frame; payload byte i is i[7:0] except in the
  // 3-byte starvation window, after which the stream is 3 bytes behind.
  task automatic build_exp(input int n_eff, input int drop_at);
    logic [31:0] crc;
    logic [7:0]  b;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 14; i++) begin
      if (i < 6)       b = dst_mac[8*i +: 8];
      else if (i < 12) b = src_mac[8*(i-6) +: 8];
      else if (i == 12) b = ethertype[15:8];
      else             b = ethertype[7:0];
      exp_q.push_back(b);
      crc = crc_upd(crc, b);
    end
    for (int i = 0; i < n_eff; i++) begin
      if (drop_at >= 0 && i >= drop_at && i < drop_at + 3) b = 8'h00;
      else if (drop_at >= 0 && i >= drop_at + 3) b = 8'(i - 3);
      else b = 8'(i);
      exp_q.push_back(b);
      crc = crc_upd(crc, b);
    end
`ifdef RGMII_FRAME_TX_PAD_EN
    for (int i = n_eff; i < 46; i++) begin
      exp_q.push_back(8'h00);
      crc = crc_upd(crc, 8'h00);
    end
`endif
    crc = ~crc;
    if (drop_at >= 0) crc = ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
  endtask

  // Runs one frame from an idle DUT; returns at the idle cycle after done.
  task automatic run_frame(input string name, input logic [10:0] n, input int drop_at);
    int n_eff, pidx, paycyc, done_k, busy_lo, nbad, sz;
    logic [31:0] fcs_got, fcs_exp;
    n_eff = (n > 11'd1500) ? 1500 : int'(n);
    build_exp(n_eff, drop_at);
    cap_q.delete();
    len = n; pidx = 0; paycyc = 0; done_k = -1; busy_lo = 0;
    start = 1'b1;
    @(posedge clk125);
    #1 start = 1'b0;
    for (int k = 1; k < 4000; k++) begin
      if (k == 2) check({name, "_pre_txctl"}, 32'(txctl), 32'h0);
      if (k == 3) check({name, "_first_nibble"}, {27'h0, txctl, txd}, 32'h15);
      if (done_k >= 0) begin
        check({name, "_busy_after_done"}, 32'(busy), 32'h0);
        break;
      end
      if (!busy) busy_lo++;
      if (done) done_k = k;
      if (s_ready) begin
        s_valid = !(drop_at >= 0 && paycyc >= drop_at && paycyc < drop_at + 3);
        s_data  = pidx[7:0];
        if (s_valid) pidx++;
        paycyc++;
      end else begin
        s_valid = 1'b1;
        s_data  = pidx[7:0];
      end
      @(posedge clk125);
      #1;
    end
    sz = exp_q.size();
    check({name, "_done_cycle"}, 32'(done_k), 32'(sz + 12));
    check({name, "_busy_low_in_frame"}, 32'(busy_lo), 32'h0);
    check({name, "_txctl_cycles"}, 32'(cap_q.size()), 32'(sz));
    nbad = 0;
    for (int i = 0; i < sz && i < cap_q.size(); i++) if (cap_q[i] !== exp_q[i]) nbad++;
    check({name, "_byte_errors"}, 32'(nbad), 32'h0);
    fcs_exp = {exp_q[sz-1], exp_q[sz-2], exp_q[sz-3], exp_q[sz-4]};
    fcs_got = 32'h0;
    if (cap_q.size() >= 4) begin
      sz = cap_q.size();
      fcs_got = {cap_q[sz-1], cap_q[sz-2], cap_q[sz-3], cap_q[sz-4]};
    end
    check({name, "_fcs"}, fcs_got, fcs_exp);
    check({name, "_ready_cycles"}, 32'(paycyc), 32'(n_eff));
    check({name, "_consumed"}, 32'(pidx), 32'(n_eff - ((drop_at >= 0) ? 3 : 0)));
    check({name, "_underrun"}, 32'(underrun), (drop_at >= 0) ? 32'h1 : 32'h0);
  endtask

  task automatic run_reset_mid();
    int dcount;
    cap_q.delete();
    len = 11'd46; s_valid = 1'b1;
    start = 1'b1;
    @(posedge clk125);
    #1 start = 1'b0;
    for (int k = 0; k < 200 && cap_q.size() < 30; k++) begin
      @(posedge clk125);
      #1;
    end
    check("rstmid_reached_byte30", 32'(cap_q.size() >= 30), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstmid_txctl", 32'(txctl), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_s_ready", 32'(s_ready), 32'h0);
    dcount = 0;
    repeat (3) begin
      @(posedge clk125);
      #1 if (done) dcount++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk125);
      #1 if (done || txctl) dcount++;
    end
    check("rstmid_no_done_no_fcs", 32'(dcount), 32'h0);
  endtask

  // start held high: expect 13 txctl-low cycles between frames, busy low for one.
  task automatic run_b2b();
    int ph, gap, blo;
    len = 11'd4; s_valid = 1'b1; start = 1'b1;
    ph = 0; gap = 0; blo = 0;
    for (int k = 0; k < 600 && ph < 4; k++) begin
      @(posedge clk125);
      #1;
      case (ph)
        0: if (txctl) ph = 1;
        1: if (!txctl) begin ph = 2; gap = 1; if (!busy) blo++; end
        2: if (txctl) begin ph = 3; start = 1'b0; end
           else begin gap++; if (!busy) blo++; end
        3: if (done) ph = 4;
        default: ph = 4;
      endcase
    end
    check("b2b_completed", 32'(ph), 32'h4);
    check("b2b_idle_gap", 32'(gap), 32'd13);
    check("b2b_busy_low_cycles", 32'(blo), 32'h1);
    @(posedge clk125);
    #1;
  endtask

  initial begin
    s_valid   = 1'b1;
    s_data    = 8'h00;
    len       = 11'd0;
    dst_mac   = 48'h665544332211;
    src_mac   = 48'hCCBBAA998877;
    ethertype = 16'h0800;
    repeat (3) @(posedge clk125);
    #1;
    check("reset_txctl", 32'(txctl), 32'h0);
    check("reset_txd", 32'(txd), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_underrun", 32'(underrun), 32'h0);
    check("reset_s_ready", 32'(s_ready), 32'h0);
    rst_n = 1'b1;
    @(posedge clk125);
    #1;

    run_frame("len46", 11'd46, -1);
    dst_mac = 48'h0123456789AB; src_mac = 48'hFEDCBA987654; ethertype = 16'h88B5;
    run_frame("len10", 11'd10, -1);
    run_frame("len2000", 11'd2000, -1);
    run_frame("drop3", 11'd46, 20);
    run_frame("after_drop", 11'd20, -1);
    run_frame("len0", 11'd0, -1);
    run_reset_mid();
    run_frame("post_reset", 11'd46, -1);
    run_b2b();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
